// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle control FSM for the shared-datapath MIPS core.
// Each instruction is sequenced through FETCH/DECODE/EXEC/MEM/WB. The
// outputs are combinational from the registered state and the IR
// opcode/func fields.
// Optional build macro MC_MEM_WAIT_EN: when defined, MEM waits for
// dm_ready and aborts with a mem_err pulse after MEM_TIMEOUT cycles.
// When it is undefined, MEM always lasts one cycle.
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       cmp_true,
    input  logic       dm_ready,
    output logic       PCWr,
    output logic [1:0] PC_sel,
    output logic       IRWr,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] DatatoReg,
    output logic       ALUSrc,
    output logic       ExtOp,
    output logic [2:0] ALUCtrl,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [2:0] state,
    output logic       illegal,
    output logic       mem_err
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BGEZ  = 6'b000001;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_OR    = 6'b100101;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // Instruction decode of the IR fields
    logic w_is_r, w_is_addu, w_is_subu, w_is_or, w_is_jr;
    logic w_is_ori, w_is_lui, w_is_sltiu, w_is_lw, w_is_sw;
    logic w_is_beq, w_is_bgez, w_is_jal, w_is_alu_r, w_legal;

    assign w_is_r     = (opcode == OP_RTYPE);
    assign w_is_addu  = w_is_r && (func == FN_ADDU);
    assign w_is_subu  = w_is_r && (func == FN_SUBU);
    assign w_is_or    = w_is_r && (func == FN_OR);
    assign w_is_jr    = w_is_r && (func == FN_JR);
    assign w_is_ori   = (opcode == OP_ORI);
    assign w_is_lui   = (opcode == OP_LUI);
    assign w_is_sltiu = (opcode == OP_SLTIU);
    assign w_is_lw    = (opcode == OP_LW);
    assign w_is_sw    = (opcode == OP_SW);
    assign w_is_beq   = (opcode == OP_BEQ);
    assign w_is_bgez  = (opcode == OP_BGEZ);
    assign w_is_jal   = (opcode == OP_JAL);
    assign w_is_alu_r = w_is_addu || w_is_subu || w_is_or;
    assign w_legal    = w_is_alu_r || w_is_jr || w_is_ori || w_is_lui ||
                        w_is_sltiu || w_is_lw || w_is_sw || w_is_beq ||
                        w_is_bgez || w_is_jal;

    logic [2:0] w_alu_ctrl;
    logic       w_alu_src;
    logic       w_ext_op;

    // ALU operation, operand source and immediate extension per instruction
    always_comb begin
        w_alu_ctrl = 3'b000;
        w_alu_src  = 1'b0;
        w_ext_op   = 1'b0;
        if (w_is_subu) begin
            w_alu_ctrl = 3'b001;
        end else if (w_is_or) begin
            w_alu_ctrl = 3'b011;
        end else if (w_is_ori) begin
            w_alu_ctrl = 3'b011;
            w_alu_src  = 1'b1;
        end else if (w_is_lui) begin
            w_alu_ctrl = 3'b100;
            w_alu_src  = 1'b1;
        end else if (w_is_sltiu) begin
            w_alu_ctrl = 3'b101;
            w_alu_src  = 1'b1;
            w_ext_op   = 1'b1;
        end else if (w_is_lw || w_is_sw) begin
            w_alu_src  = 1'b1;
            w_ext_op   = 1'b1;
        end else if (w_is_beq) begin
            w_alu_ctrl = 3'b010;
        end else if (w_is_bgez) begin
            w_alu_ctrl = 3'b110;
        end
    end

`ifdef MC_MEM_WAIT_EN
    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] r_wait_cnt;

    // MEM wait counter: zero outside MEM, counts each cycle spent waiting
    always_ff @(posedge clk) begin
        if (reset || (r_state != S_MEM)) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end
`else
    logic w_unused;
    assign w_unused = dm_ready & (MEM_TIMEOUT > 0);
`endif

    // State register; reset always returns to FETCH
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    assign state = reset ? 3'd0 : r_state;

    // Next-state and per-state control outputs; reset masks every output
    always_comb begin
        w_next    = r_state;
        PCWr      = 1'b0;
        PC_sel    = 2'b00;
        IRWr      = 1'b0;
        RegWrite  = 1'b0;
        RegDst    = 2'b00;
        DatatoReg = 2'b00;
        ALUSrc    = 1'b0;
        ExtOp     = 1'b0;
        ALUCtrl   = 3'b000;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        illegal   = 1'b0;
        mem_err   = 1'b0;

        case (r_state)
            S_FETCH: begin
                IRWr   = 1'b1;
                PCWr   = 1'b1;
                w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_is_jal) begin
                    RegWrite  = 1'b1;
                    RegDst    = 2'b10;
                    DatatoReg = 2'b10;
                    PCWr      = 1'b1;
                    PC_sel    = 2'b10;
                    w_next    = S_FETCH;
                end else if (w_is_jr) begin
                    PCWr   = 1'b1;
                    PC_sel = 2'b11;
                    w_next = S_FETCH;
                end else if (!w_legal) begin
                    illegal = 1'b1;
                    w_next  = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                ALUCtrl = w_alu_ctrl;
                ALUSrc  = w_alu_src;
                ExtOp   = w_ext_op;
                if (w_is_beq || w_is_bgez) begin
                    PCWr   = cmp_true;
                    PC_sel = 2'b01;
                    w_next = S_FETCH;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                ALUCtrl  = w_alu_ctrl;
                ALUSrc   = w_alu_src;
                ExtOp    = w_ext_op;
                MemRead  = w_is_lw;
                MemWrite = w_is_sw;
`ifdef MC_MEM_WAIT_EN
                if (dm_ready) begin
                    w_next = w_is_lw ? S_WB : S_FETCH;
                end else if (r_wait_cnt == TIMEOUT_LAST) begin
                    mem_err = 1'b1;
                    w_next  = S_FETCH;
                end else begin
                    w_next = S_MEM;
                end
`else
                w_next = w_is_lw ? S_WB : S_FETCH;
`endif
            end
            S_WB: begin
                ALUCtrl   = w_alu_ctrl;
                ALUSrc    = w_alu_src;
                ExtOp     = w_ext_op;
                RegWrite  = 1'b1;
                RegDst    = w_is_alu_r ? 2'b01 : 2'b00;
                DatatoReg = w_is_lw ? 2'b01 : 2'b00;
                w_next    = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase

        if (reset) begin
            w_next    = S_FETCH;
            PCWr      = 1'b0;
            PC_sel    = 2'b00;
            IRWr      = 1'b0;
            RegWrite  = 1'b0;
            RegDst    = 2'b00;
            DatatoReg = 2'b00;
            ALUSrc    = 1'b0;
            ExtOp     = 1'b0;
            ALUCtrl   = 3'b000;
            MemRead   = 1'b0;
            MemWrite  = 1'b0;
            illegal   = 1'b0;
            mem_err   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl: directed and random instructions are compared
// cycle by cycle against an instruction-level reference model.
module tb_mc_ctrl;

    localparam int MEM_TIMEOUT = 15;
`ifdef MC_MEM_WAIT_EN
    localparam bit FEAT = 1'b1;
`else
    localparam bit FEAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       cmp_true;
    logic       dm_ready;
    logic       PCWr;
    logic [1:0] PC_sel;
    logic       IRWr;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] DatatoReg;
    logic       ALUSrc;
    logic       ExtOp;
    logic [2:0] ALUCtrl;
    logic       MemRead;
    logic       MemWrite;
    logic [2:0] state;
    logic       illegal;
    logic       mem_err;

    int errors = 0;
    int checks = 0;

    mc_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func(func),
        .cmp_true(cmp_true), .dm_ready(dm_ready), .PCWr(PCWr),
        .PC_sel(PC_sel), .IRWr(IRWr), .RegWrite(RegWrite), .RegDst(RegDst),
        .DatatoReg(DatatoReg), .ALUSrc(ALUSrc), .ExtOp(ExtOp),
        .ALUCtrl(ALUCtrl), .MemRead(MemRead), .MemWrite(MemWrite),
        .state(state), .illegal(illegal), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       pcwr;
        logic [1:0] pcsel;
        logic       irwr;
        logic       regwr;
        logic [1:0] regdst;
        logic [1:0] d2r;
        logic       alusrc;
        logic       extop;
        logic [2:0] aluc;
        logic       memrd;
        logic       memwr;
        logic       ill;
        logic       merr;
    } exp_t;

    typedef enum {K_ILL, K_ADDU, K_SUBU, K_OR, K_JR, K_ORI, K_LUI, K_SLTIU,
                  K_LW, K_SW, K_BEQ, K_BGEZ, K_JAL} kind_t;

    // Instruction set as listed: opcode/func -> instruction
    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100001: return K_ADDU;
                    6'b100011: return K_SUBU;
                    6'b100101: return K_OR;
                    6'b001000: return K_JR;
                    default:   return K_ILL;
                endcase
            end
            6'b001101: return K_ORI;
            6'b001111: return K_LUI;
            6'b001011: return K_SLTIU;
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000001: return K_BGEZ;
            6'b000011: return K_JAL;
            default:   return K_ILL;
        endcase
    endfunction

    // {ALUCtrl, ALUSrc, ExtOp} table
    function automatic logic [4:0] alu_fields(input kind_t k);
        case (k)
            K_SUBU:      return {3'b001, 1'b0, 1'b0};
            K_OR:        return {3'b011, 1'b0, 1'b0};
            K_ORI:       return {3'b011, 1'b1, 1'b0};
            K_LUI:       return {3'b100, 1'b1, 1'b0};
            K_SLTIU:     return {3'b101, 1'b1, 1'b1};
            K_LW, K_SW:  return {3'b000, 1'b1, 1'b1};
            K_BEQ:       return {3'b010, 1'b0, 1'b0};
            K_BGEZ:      return {3'b110, 1'b0, 1'b0};
            default:     return {3'b000, 1'b0, 1'b0};
        endcase
    endfunction

    function automatic bit rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input exp_t e);
        exp_t o;
        o = '{st: state, pcwr: PCWr, pcsel: PC_sel, irwr: IRWr, regwr: RegWrite,
              regdst: RegDst, d2r: DatatoReg, alusrc: ALUSrc, extop: ExtOp,
              aluc: ALUCtrl, memrd: MemRead, memwr: MemWrite, ill: illegal,
              merr: mem_err};
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%06h expected=%06h", tag, o, e);
        end
    endtask

    // Run one instruction from FETCH to its last cycle, checking every cycle
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic cmp, input int delay, input string tag);
        exp_t  q[$];
        bit    dq[$];
        exp_t  r;
        kind_t k;
        logic [4:0] af;
        bit    done;
        bit    tmo;
        int    n;

        k    = classify(op, fn);
        af   = alu_fields(k);
        done = 1'b0;
        tmo  = 1'b0;

        r = '0; r.irwr = 1'b1; r.pcwr = 1'b1;
        q.push_back(r); dq.push_back(rbit());

        r = '0; r.st = 3'd1;
        if (k == K_JAL) begin
            r.regwr = 1'b1; r.regdst = 2'b10; r.d2r = 2'b10;
            r.pcwr = 1'b1; r.pcsel = 2'b10; done = 1'b1;
        end else if (k == K_JR) begin
            r.pcwr = 1'b1; r.pcsel = 2'b11; done = 1'b1;
        end else if (k == K_ILL) begin
            r.ill = 1'b1; done = 1'b1;
        end
        q.push_back(r); dq.push_back(rbit());

        if (!done) begin
            r = '0; r.st = 3'd2; {r.aluc, r.alusrc, r.extop} = af;
            if (k == K_BEQ || k == K_BGEZ) begin
                r.pcwr = cmp; r.pcsel = 2'b01; done = 1'b1;
            end
            q.push_back(r); dq.push_back(rbit());
        end

        if (!done && (k == K_LW || k == K_SW)) begin
            if (FEAT) begin
                n = (delay >= MEM_TIMEOUT) ? MEM_TIMEOUT : delay + 1;
                tmo = (delay >= MEM_TIMEOUT);
            end else begin
                n = 1;
            end
            for (int j = 0; j < n; j++) begin
                r = '0; r.st = 3'd3; {r.aluc, r.alusrc, r.extop} = af;
                r.memrd = (k == K_LW); r.memwr = (k == K_SW);
                r.merr = tmo && (j == n - 1);
                q.push_back(r);
                dq.push_back(FEAT ? (!tmo && (j == n - 1)) : rbit());
            end
            if (k == K_SW || tmo) done = 1'b1;
        end

        if (!done) begin
            r = '0; r.st = 3'd4; {r.aluc, r.alusrc, r.extop} = af;
            r.regwr = 1'b1;
            r.regdst = (k == K_ADDU || k == K_SUBU || k == K_OR) ? 2'b01 : 2'b00;
            r.d2r = (k == K_LW) ? 2'b01 : 2'b00;
            q.push_back(r); dq.push_back(rbit());
        end

        opcode   = op;
        func     = fn;
        cmp_true = cmp;
        for (int i = 0; i < q.size(); i++) begin
            dm_ready = dq[i];
            @(negedge clk);
            chk($sformatf("%s[%0d]", tag, i), q[i]);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        exp_t f;
        logic [5:0] rop;
        logic [5:0] rfn;
        z = '0;

        reset = 1'b1; opcode = 6'h00; func = 6'h00; cmp_true = 1'b1; dm_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("reset[%0d]", i), z);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;

        run_instr(6'b000000, 6'b100001, 1'b0, 0, "addu");
        run_instr(6'b000000, 6'b100011, 1'b1, 0, "subu");
        run_instr(6'b000000, 6'b100101, 1'b0, 0, "or");
        run_instr(6'b001101, 6'h2a,     1'b0, 0, "ori");
        run_instr(6'b001111, 6'h11,     1'b1, 0, "lui");
        run_instr(6'b001011, 6'h05,     1'b0, 0, "sltiu");
        run_instr(6'b100011, 6'h00,     1'b0, 0, "lw");
        run_instr(6'b101011, 6'h00,     1'b1, 0, "sw");
        run_instr(6'b000100, 6'h00,     1'b1, 0, "beq_t");
        run_instr(6'b000100, 6'h00,     1'b0, 0, "beq_nt");
        run_instr(6'b000001, 6'h00,     1'b1, 0, "bgez_t");
        run_instr(6'b000001, 6'h00,     1'b0, 0, "bgez_nt");
        run_instr(6'b000011, 6'h00,     1'b0, 0, "jal");
        run_instr(6'b000000, 6'b001000, 1'b0, 0, "jr");
        run_instr(6'b111111, 6'h00,     1'b0, 0, "ill_op");
        run_instr(6'b000000, 6'b000000, 1'b0, 0, "ill_fn");

        // Reset during EXEC of lw: abandoned with no MEM access
        opcode = 6'b100011; func = 6'h00; cmp_true = 1'b0; dm_ready = 1'b1;
        f = '0; f.irwr = 1'b1; f.pcwr = 1'b1;
        @(negedge clk); chk("rst_lw_fetch", f);
        @(posedge clk); #1;
        f = '0; f.st = 3'd1;
        @(negedge clk); chk("rst_lw_decode", f);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk); chk("rst_lw_exec", z);
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(6'b000000, 6'b100001, 1'b0, 0, "after_rst");

        // MEM wait behaviour (plain one-cycle MEM when the feature is off)
        run_instr(6'b100011, 6'h00, 1'b0, 3,  "lw_wait3");
        run_instr(6'b100011, 6'h00, 1'b0, 20, "lw_timeout");
        run_instr(6'b101011, 6'h00, 1'b0, 14, "sw_edge");
        run_instr(6'b100011, 6'h00, 1'b0, 14, "lw_edge");
        run_instr(6'b101011, 6'h00, 1'b0, 15, "sw_timeout");

        for (int t = 0; t < 80; t++) begin
            if (rbit()) begin
                case ($urandom_range(0, 11))
                    0:  begin rop = 6'b000000; rfn = 6'b100001; end
                    1:  begin rop = 6'b000000; rfn = 6'b100011; end
                    2:  begin rop = 6'b000000; rfn = 6'b100101; end
                    3:  begin rop = 6'b000000; rfn = 6'b001000; end
                    4:  begin rop = 6'b001101; rfn = 6'($urandom); end
                    5:  begin rop = 6'b100011; rfn = 6'($urandom); end
                    6:  begin rop = 6'b101011; rfn = 6'($urandom); end
                    7:  begin rop = 6'b000100; rfn = 6'($urandom); end
                    8:  begin rop = 6'b001111; rfn = 6'($urandom); end
                    9:  begin rop = 6'b000011; rfn = 6'($urandom); end
                    10: begin rop = 6'b001011; rfn = 6'($urandom); end
                    default: begin rop = 6'b000001; rfn = 6'($urandom); end
                endcase
            end else begin
                rop = 6'($urandom);
                rfn = 6'($urandom);
            end
            run_instr(rop, rfn, rbit(),
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 18))
                                                 : int'($urandom_range(0, 3)),
                      $sformatf("rnd%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
